// File: rtl/input_debouncer.sv
// Per-channel synchronizer plus debounce filter for raw asynchronous inputs.
// Optional feature macro: DEBOUNCE_STATUS_EN adds the per-channel busy output.
module input_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
`ifdef DEBOUNCE_STATUS_EN
  output logic [WIDTH-1:0] busy,
`endif
  output logic [WIDTH-1:0] out_clean
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [0:0] StStable   = 1'b0;
  localparam logic [0:0] StCounting = 1'b1;

  logic [SYNC_STAGES-1:0] r_sync [WIDTH];
  logic [WIDTH-1:0]       r_state;
  logic [CntW-1:0]        r_cnt  [WIDTH];
  logic [WIDTH-1:0]       r_out;

  logic [WIDTH-1:0]       w_s;
  logic [WIDTH-1:0]       w_state_d;
  logic [CntW-1:0]        w_cnt_d [WIDTH];
  logic [WIDTH-1:0]       w_out_d;

  // Plain shift chain: nothing may sit between stages or metastability can leak through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {SYNC_STAGES{RESET_LEVEL}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], in_raw[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_s[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_out_d   = r_out;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_d[i] = r_cnt[i];
      case (r_state[i])
        StStable: begin
          w_cnt_d[i] = '0;
          if (w_s[i] != r_out[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_out_d[i] = w_s[i];
            end else begin
              w_state_d[i] = StCounting;
              w_cnt_d[i]   = CntOne;
            end
          end
        end
        StCounting: begin
          if (w_s[i] == r_out[i]) begin
            w_state_d[i] = StStable;
            w_cnt_d[i]   = '0;
          end else if (r_cnt[i] == CntLast) begin
            w_out_d[i]   = w_s[i];
            w_state_d[i] = StStable;
            w_cnt_d[i]   = '0;
          end else if (r_cnt[i] != CntMax) begin
            w_cnt_d[i] = r_cnt[i] + CntOne;
          end
        end
        default: begin
          w_state_d[i] = StStable;
          w_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= {WIDTH{StStable}};
      r_out   <= {WIDTH{RESET_LEVEL}};
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign out_clean = r_out;

`ifdef DEBOUNCE_STATUS_EN
  assign busy = r_state;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed latency scenarios plus randomized bounce
// traffic checked against a sliding-window reference model.
module tb_input_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam logic        RL = 1'b0;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_raw;
  logic [W-1:0] out_clean;
  logic [W-1:0] busy;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (RL)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (in_raw),
`ifdef DEBOUNCE_STATUS_EN
    .busy     (busy),
`endif
    .out_clean(out_clean)
  );

`ifndef DEBOUNCE_STATUS_EN
  assign busy = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the synchronized level seen at edge k is in_raw sampled SS edges earlier. The
  // output takes a new value once the last DC synchronized samples all equal it.
  logic [W-1:0] m_out;
  logic [W-1:0] m_busy;
  logic [W-1:0] m_hist[$];

  initial begin
    m_out  = {W{RL}};
    m_busy = '0;
    for (int n = 0; n < SS + DC; n++) m_hist.push_back({W{RL}});
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hist.delete();
        for (int n = 0; n < SS + DC; n++) m_hist.push_back({W{RL}});
        m_out  = {W{RL}};
        m_busy = '0;
      end else begin
        m_hist.push_front(in_raw);
        void'(m_hist.pop_back());
        for (int ch = 0; ch < W; ch++) begin
          logic v;
          logic same;
          v    = m_hist[SS][ch];
          same = 1'b1;
          for (int j = 0; j < DC; j++) if (m_hist[SS+j][ch] != v) same = 1'b0;
          if (same && v != m_out[ch]) m_out[ch] = v;
        end
        m_busy = m_hist[SS] ^ m_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_raw = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_raw = 4'hF;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_clean !== 4'h0) begin
      failures++;
      $display("FAIL reset_immediate out_clean=%h want=%h", out_clean, 4'h0);
    end
`ifdef DEBOUNCE_STATUS_EN
    checks++;
    if (busy !== 4'h0) begin
      failures++;
      $display("FAIL reset_busy busy=%h want=%h", busy, 4'h0);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (out_clean !== ((k >= 6) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL reset_release edge=%0d out_clean=%h want=%h", k, out_clean,
                 (k >= 6) ? 4'hF : 4'h0);
      end
      checks++;
      if (out_clean !== m_out) begin
        failures++;
        $display("FAIL reset_model edge=%0d out_clean=%h want=%h", k, out_clean, m_out);
      end
    end
  endtask

  task automatic test_latency();
    quiet_reset();
    in_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (out_clean[0] !== (k >= 6)) begin
        failures++;
        $display("FAIL latency edge=%0d out_clean0=%b want=%b", k, out_clean[0], k >= 6);
      end
`ifdef DEBOUNCE_STATUS_EN
      checks++;
      if (busy[0] !== (k >= 3 && k <= 5)) begin
        failures++;
        $display("FAIL latency_busy edge=%0d busy0=%b want=%b", k, busy[0], k >= 3 && k <= 5);
      end
`endif
    end
  endtask

  task automatic test_short_pulse();
    quiet_reset();
    in_raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) in_raw[1] = 1'b0;
      checks++;
      if (out_clean[1] !== 1'b0 || out_clean !== m_out) begin
        failures++;
        $display("FAIL short_pulse edge=%0d out_clean=%h want=%h", k, out_clean, m_out);
      end
    end
`ifdef DEBOUNCE_STATUS_EN
    checks++;
    if (busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL short_pulse_busy busy1=%b want=0", busy[1]);
    end
`endif
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    quiet_reset();
    pat = 5'b10101;
    for (int p = 4; p >= 0; p--) begin
      in_raw[2] = pat[p];
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (out_clean[2] !== 1'b0) begin
          failures++;
          $display("FAIL bounce_hold step=%0d out_clean2=%b want=0", p, out_clean[2]);
        end
      end
    end
    // Final 1 was driven two edges ago and is still held.
    for (int k = 3; k <= 8; k++) begin
      tick();
      checks++;
      if (out_clean[2] !== (k >= 6) || out_clean !== m_out) begin
        failures++;
        $display("FAIL bounce_settle edge=%0d out_clean=%h want_bit=%b model=%h", k,
                 out_clean, k >= 6, m_out);
      end
    end
  endtask

  task automatic test_simultaneous();
    quiet_reset();
    in_raw = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (out_clean !== ((k >= 6) ? 4'b1010 : 4'b0000)) begin
        failures++;
        $display("FAIL simultaneous edge=%0d out_clean=%b want=%b", k, out_clean,
                 (k >= 6) ? 4'b1010 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    quiet_reset();
    in_raw[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    in_raw = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_clean[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL midcount_reset out_clean0=%b busy0=%b want=0/0", out_clean[0], busy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (out_clean !== 4'h0 || busy !== 4'h0) begin
        failures++;
        $display("FAIL midcount_after edge=%0d out_clean=%h busy=%h want=0/0", k, out_clean,
                 busy);
      end
    end
  endtask

  task automatic test_random();
    int hold[W];
    quiet_reset();
    for (int ch = 0; ch < W; ch++) hold[ch] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ch = 0; ch < W; ch++) begin
        if (hold[ch] == 0) begin
          in_raw[ch] = 1'($urandom_range(0, 1));
          hold[ch]   = int'($urandom_range(1, 7));
        end
        hold[ch]--;
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_clean !== m_out) begin
          failures++;
          $display("FAIL random_reset cyc=%0d out_clean=%h want=%h", cyc, out_clean, m_out);
        end
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick();
      end
      checks++;
      if (out_clean !== m_out) begin
        failures++;
        $display("FAIL random_out cyc=%0d out_clean=%h want=%h", cyc, out_clean, m_out);
      end
`ifdef DEBOUNCE_STATUS_EN
      checks++;
      if (busy !== m_busy) begin
        failures++;
        $display("FAIL random_busy cyc=%0d busy=%h want=%h", cyc, busy, m_busy);
      end
`endif
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_raw = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_latency();
    test_short_pulse();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
